// File: rtl/counter_pkg.sv
// Shared types and default constants for the 77-to-7 down-counter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } cnt_state_t;

  localparam int CNT_HIGH  = 77;
  localparam int CNT_LOW   = 7;
  localparam int CNT_WIDTH = 7;
  localparam int CNT_WRAPW = 8;

endpackage

// File: rtl/counter_load_clamp.sv
// Combinational clamp of a parallel-load value into the counting range [LOW,HIGH].
module counter_load_clamp
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int HIGH  = CNT_HIGH,
  parameter int LOW   = CNT_LOW
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] clamped
);

  localparam logic [WIDTH-1:0] HIGH_V = WIDTH'(HIGH);
  localparam logic [WIDTH-1:0] LOW_V  = WIDTH'(LOW);

  always_comb begin
    clamped = value;
    if (value < LOW_V) begin
      clamped = LOW_V;
    end else if (value > HIGH_V) begin
      clamped = HIGH_V;
    end
  end

endmodule

// File: rtl/counter_77to7_down.sv
// Down-counter HIGH..LOW with start/stop/pause, clamped load, tc pulse and wrap count.
// Define COUNTER_DOWN_TICK_EN to add a tick input that gates counting in RUN.
module counter_77to7_down
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int HIGH  = CNT_HIGH,
  parameter int LOW   = CNT_LOW,
  parameter int WRAPW = CNT_WRAPW
) (
  input  logic             clock,
  input  logic             reset,
`ifdef COUNTER_DOWN_TICK_EN
  input  logic             tick,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             oneshot,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [WRAPW-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] HIGH_V = WIDTH'(HIGH);
  localparam logic [WIDTH-1:0] LOW_V  = WIDTH'(LOW);

  cnt_state_t       state;
  cnt_state_t       next_state;
  logic [WIDTH-1:0] next_counter;
  logic [WIDTH-1:0] clamped;
  logic [WRAPW-1:0] next_wrap;
  logic             next_tc;
  logic             tick_en;

`ifdef COUNTER_DOWN_TICK_EN
  assign tick_en = tick;
`else
  assign tick_en = 1'b1;
`endif

  counter_load_clamp #(
    .WIDTH (WIDTH),
    .HIGH  (HIGH),
    .LOW   (LOW)
  ) u_clamp (
    .value   (load_value),
    .clamped (clamped)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= HIGH_V;
      tc       <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      state    <= next_state;
      counter  <= next_counter;
      tc       <= next_tc;
      wrap_cnt <= next_wrap;
    end
  end

  // Priority: load > stop > start > count; tc is registered so it lags the LOW edge by one cycle.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    next_tc      = 1'b0;
    next_wrap    = wrap_cnt;
    if (load) begin
      next_counter = clamped;
      if (state == DONE) begin
        next_state = IDLE;
      end
    end else if (stop) begin
      if (state == RUN) begin
        next_state = PAUSE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state = RUN;
          end
        end
        PAUSE: begin
          if (start) begin
            next_state = RUN;
          end
        end
        DONE: begin
          if (start) begin
            next_state   = RUN;
            next_counter = HIGH_V;
          end
        end
        RUN: begin
          if (tick_en) begin
            if (counter > LOW_V) begin
              next_counter = counter - WIDTH'(1);
            end else begin
              next_tc = 1'b1;
              if (oneshot) begin
                next_state = DONE;
              end else begin
                next_counter = HIGH_V;
                next_wrap    = wrap_cnt + WRAPW'(1);
              end
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_77to7_down.sv
// Self-checking bench for counter_77to7_down: vector table plus multi-cycle sequences.
module tb_counter_77to7_down;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       start;
  logic       stop;
  logic       load;
  logic [6:0] load_value;
  logic       oneshot;
  logic [6:0] counter;
  logic       tc;
  logic       busy;
  logic       done;
  logic [7:0] wrap_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       load;
    logic [6:0] lv;
    logic       start;
    logic       stop;
    logic       oneshot;
    logic [6:0] ec;
    logic       etc;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t vecs[20];

  counter_77to7_down dut (
    .clock      (clock),
    .reset      (reset),
`ifdef COUNTER_DOWN_TICK_EN
    .tick       (tick),
`endif
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .oneshot    (oneshot),
    .counter    (counter),
    .tc         (tc),
    .busy       (busy),
    .done       (done),
    .wrap_cnt   (wrap_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic l, input logic [6:0] v, input logic o);
    reset      = r;
    start      = s;
    stop       = p;
    load       = l;
    load_value = v;
    oneshot    = o;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] ec, input logic etc,
                             input logic ebusy, input logic edone, input logic [7:0] ewrap);
    tests_run++;
    if (counter !== ec || tc !== etc || busy !== ebusy || done !== edone || wrap_cnt !== ewrap) begin
      tests_failed++;
      $display("[TB] FAIL %s: got counter=%0d tc=%b busy=%b done=%b wrap=%0d, want counter=%0d tc=%b busy=%b done=%b wrap=%0d",
               name, counter, tc, busy, done, wrap_cnt, ec, etc, ebusy, edone, ewrap);
    end
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 7'd0, 0);
    applyStimulus(1, 0, 0, 0, 7'd0, 0);
    applyStimulus(0, 0, 0, 0, 7'd0, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 7'd3,   0, 0, 0, 7'd7,  0, 0, 0};
    vecs[1]  = '{1, 7'd100, 0, 0, 0, 7'd77, 0, 0, 0};
    vecs[2]  = '{1, 7'd40,  0, 0, 0, 7'd40, 0, 0, 0};
    vecs[3]  = '{1, 7'd0,   0, 0, 0, 7'd7,  0, 0, 0};
    vecs[4]  = '{1, 7'd127, 0, 0, 0, 7'd77, 0, 0, 0};
    vecs[5]  = '{1, 7'd8,   0, 0, 0, 7'd8,  0, 0, 0};
    vecs[6]  = '{1, 7'd76,  0, 0, 0, 7'd76, 0, 0, 0};
    vecs[7]  = '{1, 7'd40,  0, 0, 0, 7'd40, 0, 0, 0};
    vecs[8]  = '{0, 7'd0,   1, 0, 0, 7'd40, 0, 1, 0};
    vecs[9]  = '{0, 7'd0,   0, 0, 0, 7'd39, 0, 1, 0};
    vecs[10] = '{0, 7'd0,   1, 1, 0, 7'd39, 0, 1, 0};
    vecs[11] = '{0, 7'd0,   0, 1, 0, 7'd39, 0, 1, 0};
    vecs[12] = '{0, 7'd0,   1, 0, 0, 7'd39, 0, 1, 0};
    vecs[13] = '{0, 7'd0,   0, 0, 0, 7'd38, 0, 1, 0};
    vecs[14] = '{1, 7'd8,   0, 0, 0, 7'd8,  0, 1, 0};
    vecs[15] = '{0, 7'd0,   0, 0, 0, 7'd7,  0, 1, 0};
    vecs[16] = '{0, 7'd0,   0, 0, 1, 7'd7,  1, 0, 1};
    vecs[17] = '{0, 7'd0,   0, 0, 1, 7'd7,  0, 0, 1};
    vecs[18] = '{1, 7'd50,  0, 0, 0, 7'd50, 0, 0, 0};
    vecs[19] = '{0, 7'd0,   0, 0, 0, 7'd50, 0, 0, 0};

    tick = 1'b1;

    // Reset held two cycles, then idle.
    applyStimulus(1, 1, 0, 0, 7'd0, 0);
    checkOutput("reset_cycle1", 7'd77, 0, 0, 0, 8'd0);
    applyStimulus(1, 0, 0, 1, 7'd20, 0);
    checkOutput("reset_cycle2", 7'd77, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 7'd0, 0);
      checkOutput($sformatf("idle_%0d", i), 7'd77, 0, 0, 0, 8'd0);
    end

    // Vector table: clamped loads, start/stop/pause, oneshot termination, load in DONE.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, vecs[i].start, vecs[i].stop, vecs[i].load, vecs[i].lv, vecs[i].oneshot);
      checkOutput($sformatf("vec_%0d", i), vecs[i].ec, vecs[i].etc, vecs[i].ebusy, vecs[i].edone, 8'd0);
    end

    // Periodic: full sweep, first wrap, second wrap 71 cycles later, then reset mid-count.
    doReset();
    applyStimulus(0, 1, 0, 0, 7'd0, 0);
    checkOutput("per_start", 7'd77, 0, 1, 0, 8'd0);
    for (int k = 1; k <= 70; k++) begin
      applyStimulus(0, 0, 0, 0, 7'd0, 0);
      checkOutput($sformatf("per_dec_%0d", k), 7'(77 - k), 0, 1, 0, 8'd0);
    end
    applyStimulus(0, 0, 0, 0, 7'd0, 0);
    checkOutput("per_wrap1", 7'd77, 1, 1, 0, 8'd1);
    for (int k = 1; k <= 70; k++) begin
      applyStimulus(0, 0, 0, 0, 7'd0, 0);
      checkOutput($sformatf("per2_dec_%0d", k), 7'(77 - k), 0, 1, 0, 8'd1);
    end
    applyStimulus(0, 0, 0, 0, 7'd0, 0);
    checkOutput("per_wrap2", 7'd77, 1, 1, 0, 8'd2);
    for (int k = 1; k <= 5; k++) applyStimulus(0, 0, 0, 0, 7'd0, 0);
    checkOutput("per_mid", 7'd72, 0, 1, 0, 8'd2);
    applyStimulus(1, 1, 0, 0, 7'd0, 0);
    checkOutput("per_reset_mid", 7'd77, 0, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 0, 7'd0, 0);
    checkOutput("per_after_reset", 7'd77, 0, 0, 0, 8'd0);

    // Oneshot: park at LOW, single tc, restart from DONE.
    applyStimulus(0, 1, 0, 0, 7'd0, 1);
    checkOutput("os_start", 7'd77, 0, 1, 0, 8'd0);
    for (int k = 1; k <= 70; k++) applyStimulus(0, 0, 0, 0, 7'd0, 1);
    checkOutput("os_at_low", 7'd7, 0, 1, 0, 8'd0);
    applyStimulus(0, 0, 0, 0, 7'd0, 1);
    checkOutput("os_done", 7'd7, 1, 0, 1, 8'd0);
    applyStimulus(0, 0, 0, 0, 7'd0, 1);
    checkOutput("os_hold", 7'd7, 0, 0, 1, 8'd0);
    applyStimulus(0, 1, 0, 0, 7'd0, 0);
    checkOutput("os_restart", 7'd77, 0, 1, 0, 8'd0);
    applyStimulus(0, 0, 0, 0, 7'd0, 0);
    checkOutput("os_restart_dec", 7'd76, 0, 1, 0, 8'd0);

    // Stop at 50 with start held, then resume.
    doReset();
    applyStimulus(0, 1, 0, 0, 7'd0, 0);
    for (int k = 1; k <= 27; k++) applyStimulus(0, 0, 0, 0, 7'd0, 0);
    checkOutput("stop_reach50", 7'd50, 0, 1, 0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 1, 0, 7'd0, 0);
      checkOutput($sformatf("stop_hold_%0d", k), 7'd50, 0, 1, 0, 8'd0);
    end
    applyStimulus(0, 1, 0, 0, 7'd0, 0);
    checkOutput("stop_resume", 7'd50, 0, 1, 0, 8'd0);
    applyStimulus(0, 0, 0, 0, 7'd0, 0);
    checkOutput("stop_resume_dec", 7'd49, 0, 1, 0, 8'd0);

`ifdef COUNTER_DOWN_TICK_EN
    // Tick every third cycle gates the decrement; reset at 30 restores HIGH.
    doReset();
    tick = 1'b0;
    applyStimulus(0, 1, 0, 0, 7'd0, 0);
    checkOutput("tick_start", 7'd77, 0, 1, 0, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      tick = (k % 3 == 0);
      applyStimulus(0, 0, 0, 0, 7'd0, 0);
      checkOutput($sformatf("tick_%0d", k), 7'(77 - k / 3), 0, 1, 0, 8'd0);
    end
    tick = 1'b0;
    applyStimulus(0, 0, 0, 1, 7'd30, 0);
    checkOutput("tick_load30", 7'd30, 0, 1, 0, 8'd0);
    applyStimulus(1, 0, 0, 0, 7'd0, 0);
    checkOutput("tick_reset", 7'd77, 0, 0, 0, 8'd0);
    tick = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
